// File: rtl/gpr_pkg.sv
// Shared GPR definitions: register count, select codes and decode helper.
// Used by both the GPR write bank and the GPR read mux.
package gpr_pkg;

    localparam int NUM_GPR = 13;
    localparam int DATA_W_DEF = 32;

    typedef logic [3:0] gpr_sel_t;

    localparam gpr_sel_t SEL_A = 4'd0;
    localparam gpr_sel_t SEL_B = 4'd1;
    localparam gpr_sel_t SEL_C = 4'd2;
    localparam gpr_sel_t SEL_D = 4'd3;
    localparam gpr_sel_t SEL_E = 4'd4;
    localparam gpr_sel_t SEL_F = 4'd5;
    localparam gpr_sel_t SEL_G = 4'd6;
    localparam gpr_sel_t SEL_H = 4'd7;
    localparam gpr_sel_t SEL_I = 4'd8;
    localparam gpr_sel_t SEL_J = 4'd9;
    localparam gpr_sel_t SEL_K = 4'd10;
    localparam gpr_sel_t SEL_L = 4'd11;
    localparam gpr_sel_t SEL_M = 4'd12;

    // Codes 13..15 decode to no register at all.
    function automatic logic [NUM_GPR-1:0] sel_onehot(
        input gpr_sel_t sel
    );
        logic [NUM_GPR-1:0] oh;
        oh = '0;
        if (sel < gpr_sel_t'(NUM_GPR)) begin
            oh[sel] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// In-order writeback queue: DEPTH entries of {sel, data}.
// Exposes per-entry valid/sel so the owner can build hazard bits.
module gpr_wb_fifo
    import gpr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  gpr_sel_t               push_sel,
    input  logic [DATA_W-1:0]      push_data,
    output logic                   full,
    output logic                   empty,
    output gpr_sel_t               head_sel,
    output logic [DATA_W-1:0]      head_data,
    output logic [DEPTH-1:0]       ent_valid,
    output gpr_sel_t [DEPTH-1:0]   ent_sel
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;
    gpr_sel_t [DEPTH-1:0] mem_sel;
    logic [DATA_W-1:0]    mem_data [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count
                   + {{PW{1'b0}}, do_push}
                   - {{PW{1'b0}}, do_pop};
        end
    end

    // Payload needs no reset; it is only observed under ent_valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_sel[wr_ptr]  <= push_sel;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
        end
    end

    assign ent_sel   = mem_sel;
    assign head_sel  = mem_sel[rd_ptr];
    assign head_data = mem_data[rd_ptr];

endmodule

// File: rtl/gpr_write_bank.sv
// GPR write side: queues writebacks, retires one per cycle into rA..rM,
// and publishes per-register pending bits for RAW stalls in decode.
module gpr_write_bank
    import gpr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [3:0]         wb_sel,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               wb_hold,
    input  logic               flush,
    output logic [DATA_W-1:0]  rA,
    output logic [DATA_W-1:0]  rB,
    output logic [DATA_W-1:0]  rC,
    output logic [DATA_W-1:0]  rD,
    output logic [DATA_W-1:0]  rE,
    output logic [DATA_W-1:0]  rF,
    output logic [DATA_W-1:0]  rG,
    output logic [DATA_W-1:0]  rH,
    output logic [DATA_W-1:0]  rI,
    output logic [DATA_W-1:0]  rJ,
    output logic [DATA_W-1:0]  rK,
    output logic [DATA_W-1:0]  rL,
    output logic [DATA_W-1:0]  rM,
    output logic [NUM_GPR-1:0] pending,
    output logic               sel_err
);

    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 sel_ok;
    logic                 push;
    logic                 pop;
    logic                 retire;
    gpr_sel_t             head_sel;
    logic [DATA_W-1:0]    head_data;
    logic [DEPTH-1:0]     ent_valid;
    gpr_sel_t [DEPTH-1:0] ent_sel;
    logic [DATA_W-1:0]    regs [NUM_GPR];

    assign wb_ready = !full;
    assign accept   = wb_valid && wb_ready;
    assign sel_ok   = (wb_sel < gpr_sel_t'(NUM_GPR));
    assign push     = accept && sel_ok;
    assign pop      = !wb_hold && !empty;
    assign retire   = pop && !flush;

    gpr_wb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_sel  (wb_sel),
        .push_data (wb_data),
        .full      (full),
        .empty     (empty),
        .head_sel  (head_sel),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_sel   (ent_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                regs[i] <= '0;
            end
        end else if (retire) begin
            regs[head_sel] <= head_data;
        end
    end

    // Invalid codes are swallowed by the handshake and only flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept && !sel_ok;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pending = pending | sel_onehot(ent_sel[i]);
            end
        end
    end

    assign rA = regs[SEL_A];
    assign rB = regs[SEL_B];
    assign rC = regs[SEL_C];
    assign rD = regs[SEL_D];
    assign rE = regs[SEL_E];
    assign rF = regs[SEL_F];
    assign rG = regs[SEL_G];
    assign rH = regs[SEL_H];
    assign rI = regs[SEL_I];
    assign rJ = regs[SEL_J];
    assign rK = regs[SEL_K];
    assign rL = regs[SEL_L];
    assign rM = regs[SEL_M];

endmodule

// File: tb/tb_gpr_write_bank.sv
// Bench for gpr_write_bank: directed writebacks with an expected-write
// queue drained by a monitor that watches register and sel_err changes.
module tb_gpr_write_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_data = '0;
    logic        wb_hold = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rA, rB, rC, rD, rE, rF, rG;
    logic [31:0] rH, rI, rJ, rK, rL, rM;
    logic [12:0] pending;
    logic        sel_err;

    logic [31:0] rr [13];

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
    } exp_t;

    exp_t exp_wr [$];
    int   exp_err = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpr_write_bank dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_sel   (wb_sel),
        .wb_data  (wb_data),
        .wb_hold  (wb_hold),
        .flush    (flush),
        .rA       (rA),
        .rB       (rB),
        .rC       (rC),
        .rD       (rD),
        .rE       (rE),
        .rF       (rF),
        .rG       (rG),
        .rH       (rH),
        .rI       (rI),
        .rJ       (rJ),
        .rK       (rK),
        .rL       (rL),
        .rM       (rM),
        .pending  (pending),
        .sel_err  (sel_err)
    );

    assign rr[0]  = rA;
    assign rr[1]  = rB;
    assign rr[2]  = rC;
    assign rr[3]  = rD;
    assign rr[4]  = rE;
    assign rr[5]  = rF;
    assign rr[6]  = rG;
    assign rr[7]  = rH;
    assign rr[8]  = rI;
    assign rr[9]  = rJ;
    assign rr[10] = rK;
    assign rr[11] = rL;
    assign rr[12] = rM;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request; returns at accept edge + 1.
    task automatic push(input logic [3:0] s, input logic [31:0] d);
        int   n;
        logic rdy;
        exp_t e;
        n = 0;
        wb_valid = 1'b1;
        wb_sel   = s;
        wb_data  = d;
        do begin
            @(negedge clk);
            rdy = wb_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        wb_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: sel %0d not accepted", s);
        end else if (s < 4'd13) begin
            e.sel  = s;
            e.data = d;
            exp_wr.push_back(e);
        end else begin
            exp_err++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register change must be the next expected retire.
    initial begin
        logic [31:0] prev [13];
        exp_t        e;
        for (int k = 0; k < 13; k++) prev[k] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 13; k++) prev[k] = rr[k];
            end else begin
                for (int k = 0; k < 13; k++) begin
                    if (rr[k] !== prev[k]) begin
                        checks++;
                        if (exp_wr.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write: r%0d got %h",
                                     k, rr[k]);
                        end else begin
                            e = exp_wr.pop_front();
                            if (e.sel != k[3:0] || e.data !== rr[k]) begin
                                errors++;
                                $display("FAIL retire: r%0d=%h expected r%0d=%h",
                                         k, rr[k], e.sel, e.data);
                            end
                        end
                        prev[k] = rr[k];
                    end
                end
                if (sel_err) begin
                    checks++;
                    if (exp_err == 0) begin
                        errors++;
                        $display("FAIL sel_err: got 1 expected 0");
                    end else begin
                        exp_err--;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 13; k++) check("reset_reg", rr[k], 32'h0);
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_ready", 32'(wb_ready), 32'h1);
        check("reset_sel_err", 32'(sel_err), 32'h0);

        // Single write: pending the edge after accept, value one edge later.
        push(4'd3, 32'hDEADBEEF);
        check("single_pending", 32'(pending), 32'h0008);
        check("single_rd_before", rD, 32'h0);
        step();
        check("single_rd", rD, 32'hDEADBEEF);
        check("single_pending_clr", 32'(pending), 32'h0);

        // Back-pressure with hold.
        wb_hold = 1'b1;
        push(4'd0, 32'h1);
        push(4'd12, 32'h2);
        check("bp_ready", 32'(wb_ready), 32'h0);
        check("bp_pending", 32'(pending), 32'h1001);
        wb_hold = 1'b0;
        step();
        check("bp_ra", rA, 32'h1);
        check("bp_rm_before", rM, 32'h0);
        check("bp_ready_back", 32'(wb_ready), 32'h1);
        check("bp_pending1", 32'(pending), 32'h1000);
        step();
        check("bp_rm", rM, 32'h2);
        check("bp_pending2", 32'(pending), 32'h0);

        // Same register twice: last write wins.
        wb_hold = 1'b1;
        push(4'd5, 32'hA);
        push(4'd5, 32'hB);
        check("same_pending", 32'(pending), 32'h0020);
        wb_hold = 1'b0;
        step();
        check("same_rf1", rF, 32'hA);
        check("same_pending1", 32'(pending), 32'h0020);
        step();
        check("same_rf2", rF, 32'hB);
        check("same_pending2", 32'(pending), 32'h0);

        // Invalid select.
        push(4'd14, 32'h55);
        check("inv_sel_err", 32'(sel_err), 32'h1);
        check("inv_pending", 32'(pending), 32'h0);
        check("inv_ready", 32'(wb_ready), 32'h1);
        step();
        check("inv_sel_err_clr", 32'(sel_err), 32'h0);

        // Push and pop on the same edge at count = DEPTH-1.
        wb_hold = 1'b1;
        push(4'd6, 32'h66);
        wb_hold = 1'b0;
        push(4'd7, 32'h77);
        check("pp_rg", rG, 32'h66);
        check("pp_pending", 32'(pending), 32'h0080);
        step();
        check("pp_rh", rH, 32'h77);
        check("pp_pending_clr", 32'(pending), 32'h0);

        // Back-to-back stream exercising pointer wrap.
        for (int i = 0; i < 4; i++) push(4'(9 + i), 32'h1000 + i);
        step();
        for (int i = 0; i < 4; i++)
            check("stream", rr[9 + i], 32'h1000 + i);

        // Flush drops queued writes; registers keep old values.
        push(4'd1, 32'h111);
        push(4'd2, 32'h222);
        step();
        wb_hold = 1'b1;
        push(4'd1, 32'h999);
        push(4'd2, 32'h888);
        check("fl_full", 32'(wb_ready), 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_wr.delete();
        check("fl_pending", 32'(pending), 32'h0);
        check("fl_ready", 32'(wb_ready), 32'h1);
        wb_hold = 1'b0;
        repeat (3) step();
        check("fl_rb", rB, 32'h111);
        check("fl_rc", rC, 32'h222);

        // Asynchronous reset mid-cycle with a full queue.
        wb_hold = 1'b1;
        push(4'd4, 32'h44);
        push(4'd10, 32'hAA);
        check("ar_pending_pre", 32'(pending), 32'h0410);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_wr.delete();
        for (int k = 0; k < 13; k++) check("areset_reg", rr[k], 32'h0);
        check("areset_pending", 32'(pending), 32'h0);
        check("areset_ready", 32'(wb_ready), 32'h1);
        wb_hold = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("ar_re_dropped", rE, 32'h0);
        check("ar_rk_dropped", rK, 32'h0);

        push(4'd0, 32'h77);
        step();
        check("post_reset_ra", rA, 32'h77);

        repeat (3) step();
        check("drain_writes", 32'(exp_wr.size()), 32'h0);
        check("drain_sel_err", 32'(exp_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_write_bank.md
Name: gpr_write_bank

Overview:
- Write side of the general-purpose register file. It owns the 13 x 32-bit registers rA..rM that the GPR read mux selects from.
- Accepts writeback requests over a valid/ready handshake and buffers them in a 2-entry in-order queue.
- Retires at most one write per cycle, unless held off by wb_hold.
- Exports per-register pending bits so decode can stall on read-after-write hazards.

Parameters:
- DATA_W, 32, register width.
- NUM_GPR, 13, number of architectural registers; sel codes 0..12 map to rA..rM.
- DEPTH, 2, writeback queue depth; must be a power of two, 2 or more.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  writeback request present.
- wb_ready  out  1  queue can accept; a transfer occurs when wb_valid and wb_ready are both high.
- wb_sel  in  4  destination register code; 0=rA .. 12=rM; 13..15 invalid.
- wb_data  in  DATA_W  write data.
- wb_hold  in  1  blocks retirement (pop) this cycle; accepting still allowed.
- flush  in  1  synchronous discard of all queued, not-yet-retired writes.
- rA..rM  out  DATA_W each  register contents; feed the GPR read mux directly.
- pending  out  NUM_GPR  bit k high while any queued entry targets register k.
- sel_err  out  1  one-cycle pulse: an invalid wb_sel was accepted.

Behaviour:
- Reset (asynchronous, while rst is high):
  - rA..rM = 0; queue empty; pending = 0; sel_err = 0.
  - wb_ready = 1, since it is combinational from the count.
  - Reset mid-operation drops all queued writes; registers still clear to 0.
- Handshake:
  - wb_ready = (count != DEPTH); it never depends on wb_valid.
  - wb_sel and wb_data are sampled on the accepting edge.
  - A request held with wb_ready low must stay stable; this is checked by the bench, not the RTL.
- Invalid sel (13..15):
  - Accepted normally when wb_ready is high, but no queue entry is created.
  - sel_err goes high on the cycle after the accepting edge, for exactly one cycle; no register changes.
- Retire:
  - Each edge where the queue is non-empty and wb_hold is low, pop the head and write its data to its register.
  - Latency: a request accepted at edge N into an empty queue is retired at edge N+1. The new value is visible on rX after edge N+1.
- Simultaneous push and pop:
  - Allowed, including when count = DEPTH-1.
  - When full, wb_ready is low, so no push and pop can coincide at the full boundary.
- Ordering:
  - Strict FIFO order; two queued writes to the same register retire in order, and the last one wins.
- Pending:
  - pending = OR over valid entries of onehot(sel), registered alongside the queue.
  - A bit is set the cycle after accept. It clears the cycle after the last matching entry retires.
- Flush:
  - On the edge where flush is high, count -> 0 and pending -> 0. No retire happens that edge, and a concurrent push is dropped.
  - An invalid sel accepted on that edge still pulses sel_err.
  - Registers keep their current values.
- Wrap-around: read and write pointers are log2(DEPTH) bits wide and wrap naturally. Count has log2(DEPTH)+1 bits.
- No read bypass: rX reflects only retired writes.

Decomposition:
- Package gpr_pkg holds:
  - NUM_GPR and the DATA_W default.
  - typedef gpr_sel_t (logic [3:0]).
  - Constants SEL_A..SEL_M (0..12).
  - Function sel_onehot (gpr_sel_t -> logic [NUM_GPR-1:0]; all zeros for invalid codes).
  - The same package is shared by the GPR read mux.
- Sub-module gpr_wb_fifo: generic DEPTH x (4+DATA_W) queue exposing push, pop, full, empty, head, and per-entry valid and sel for pending generation.
- Top level: decode, register array, sel_err, and pending logic.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all rX = 0, pending = 0, wb_ready = 1 without waiting for a clk edge.
- Single write: sel=3, data=0xDEADBEEF, accepted at edge N -> pending[3]=1 after edge N. After edge N+1: rD=0xDEADBEEF and pending[3]=0. All other registers unchanged.
- Back-pressure: wb_hold=1, push sel=0/data=1 then sel=12/data=2 -> wb_ready=0 after the 2nd accept and pending=13'h1001. Release the hold -> rA=1, then rM=2 on consecutive edges, and wb_ready=1 again.
- Same-register ordering: hold, push sel=5 with 0xA then sel=5 with 0xB, release -> rF goes 0xA then 0xB. pending[5] stays high until the second retire.
- Invalid sel: push sel=14, data=0x55 -> sel_err pulses for one cycle, no register changes, pending stays 0, wb_ready stays 1.
- Flush: hold with 2 entries queued (sel=1, sel=2), assert flush for one cycle -> pending=0 and wb_ready=1. After releasing the hold, rB and rC keep their prior values.
